// File: rtl/cdf_pkg.sv
// cdf_pkg: shared state encoding and sizing constants for the CDF sequencer.
package cdf_pkg;
  typedef enum logic [2:0] {IDLE, READ, WAIT, READY, WR_LO, WR_HI, DONE} cdf_state_t;
  localparam int CDF_NUM_BINS      = 256;
  localparam int CDF_BINS_PER_STEP = 8;
  localparam int CDF_DEF_MEM_LAT   = 3;
endpackage

// File: rtl/cdf_wait_counter.sv
// cdf_wait_counter: loadable down-counter timing the scratch-memory read latency.
module cdf_wait_counter #(
  parameter int MEM_LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);
  localparam int W = $clog2(MEM_LAT) + 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? W'(MEM_LAT - 1) : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // high when the count lands on zero with this cycle's decrement
  assign zero_o = cnt_q <= W'(1);
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/cdf_controller.sv
// cdf_controller: sequences the CDF datapath strobes over NUM_STEPS 8-bin steps per pass.
module cdf_controller
  import cdf_pkg::*;
#(
  parameter int NUM_STEPS = CDF_NUM_BINS / CDF_BINS_PER_STEP,
  parameter int MEM_LAT   = CDF_DEF_MEM_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        read_first_value,
  output logic        read_next_value,
  output logic        scratch_mem_read_ready,
  output logic        cdf_computation_done,
  output logic        cdf_done,
  output logic [15:0] step_cnt
);
  cdf_state_t state_q, state_d;
  logic [15:0] step_q, step_d;
  logic ld, dec, wait_zero;
  logic busy_q, done_q, rfv_q, rnv_q, rdy_q, cmp_q;
  cdf_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .load_i (ld),
    .dec_i  (dec),
    .zero_o (wait_zero)
  );
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ld      = 1'b0;
    dec     = 1'b0;
    case (state_q)
      IDLE:  state_d = start ? READ : IDLE;
      READ: begin
        ld      = 1'b1;
        state_d = (MEM_LAT == 1) ? READY : WAIT;
      end
      WAIT: begin
        dec     = 1'b1;
        state_d = wait_zero ? READY : WAIT;
      end
      READY: state_d = WR_LO;
      WR_LO: state_d = WR_HI;
      WR_HI: begin
        state_d = (step_q == 16'(NUM_STEPS - 1)) ? DONE : READ;
        step_d  = (step_q == 16'(NUM_STEPS - 1)) ? step_q : step_q + 16'd1;
      end
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // strobes are decoded from the next state so every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rfv_q   <= 1'b0;
      rnv_q   <= 1'b0;
      rdy_q   <= 1'b0;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      rfv_q   <= state_d == READ && step_d == '0;
      rnv_q   <= state_d == READ && step_d != '0;
      rdy_q   <= state_d == READY;
      cmp_q   <= state_d == WR_LO || state_d == WR_HI;
    end
  end
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign cdf_done               = done_q;
  assign read_first_value       = rfv_q;
  assign read_next_value        = rnv_q;
  assign scratch_mem_read_ready = rdy_q;
  assign cdf_computation_done   = cmp_q;
  assign step_cnt               = step_q;
endmodule

// File: doc/cdf_controller.md
# cdf_controller

Sequencing FSM for the CDF datapath. On a `start` pulse it drives the datapath control strobes (first read, memory-ready, per-half write, next read, done) for `NUM_STEPS` steps of 8 histogram bins each, then reports completion. It sits between the top-level equalization sequencer (`start`/`busy`/`done`) and the CDF datapath's control inputs. The datapath registers every strobe once; all timing below is at this block's outputs.

## Interface
Parameters:
- `NUM_STEPS`, 32, number of 8-bin steps (256 bins / 8); legal range 1..65535
- `MEM_LAT`, 3, cycles from a read strobe to the matching `scratch_mem_read_ready` (≥1)

Ports:
- `clk` in 1, clock
- `reset` in 1, synchronous, active-high
- `start` in 1, begin a CDF pass; sampled only in IDLE
- `busy` out 1, high in every state except IDLE
- `done` out 1, one-cycle pulse, coincident with `cdf_done`
- `read_first_value` out 1, pulse: datapath loads read addresses 0/1
- `read_next_value` out 1, pulse: datapath advances read addresses by 2
- `scratch_mem_read_ready` out 1, pulse: datapath latches the 8 CDF sums
- `cdf_computation_done` out 1, pulse: datapath writes one 4-bin half, updates carry
- `cdf_done` out 1, pulse: pass complete
- `step_cnt` out 16, index of the current step (0..NUM_STEPS-1)

## Operation
- States: IDLE, READ, WAIT, READY, WR_LO, WR_HI, DONE.
- IDLE → READ on `start`=1. `start` is ignored in every other state.
- READ (1 cycle): `read_first_value`=1 when `step_cnt`==0, else `read_next_value`=1. Load wait counter with MEM_LAT-1.
- WAIT (MEM_LAT-1 cycles; skipped when MEM_LAT=1): counter decrements to 0, then → READY.
- READY (1 cycle): `scratch_mem_read_ready`=1 → WR_LO.
- WR_LO (1 cycle): `cdf_computation_done`=1 → WR_HI.
- WR_HI (1 cycle): `cdf_computation_done`=1. If `step_cnt`==NUM_STEPS-1 → DONE; else increment `step_cnt` → READ.
- DONE (1 cycle): `cdf_done`=1, `done`=1 → IDLE. `step_cnt` clears to 0.
- At most one strobe is high in any cycle. `step_cnt` is 16 bits with no wrap, because NUM_STEPS ≤ 65535.
- Reset (any state, including mid-pass): next cycle state=IDLE. All outputs are 0 and `step_cnt`=0. No partial strobe is emitted.

## Timing
- All outputs are registered Moore outputs. Reset value of every output is 0.
- Each step lasts MEM_LAT+3 cycles. With the defaults, a step is 6 cycles.
- If `start` is sampled high at edge k, READ occupies cycle k+1. The pass occupies k+1 .. k+NUM_STEPS·(MEM_LAT+3). DONE is the next cycle. `busy` falls one cycle after DONE.
- Defaults: pass = 192 cycles, `done` at k+193, `busy` low at k+194.
- Per pass: exactly 1 `read_first_value`, NUM_STEPS-1 `read_next_value`, NUM_STEPS `scratch_mem_read_ready`, 2·NUM_STEPS `cdf_computation_done`, 1 `cdf_done`.
- `start` high in the DONE cycle is ignored. `start` high in the first IDLE cycle after DONE starts a new pass.

## Structure
- Shared package `cdf_pkg`: state enum `cdf_state_t`, `CDF_NUM_BINS`=256, `CDF_BINS_PER_STEP`=8, `CDF_DEF_MEM_LAT`=3.
- Sub-module `cdf_wait_counter`: loadable down-counter with `zero` flag, width `$clog2(MEM_LAT)+1`. The FSM and the step counter stay in the top module.

## Test plan
- Reset then idle 10 cycles: all outputs 0, `busy`=0, `step_cnt`=0.
- `start` at edge 0 (defaults): `read_first_value` at cycle 1, `scratch_mem_read_ready` at cycle 4, `cdf_computation_done` at cycles 5 and 6, `read_next_value` at cycle 7. `done`/`cdf_done` at cycle 193; `busy` low at 194. Strobe counts are 1/31/32/64/1.
- NUM_STEPS=1, MEM_LAT=1: `start` at 0 → READ 1, READY 2, WR 3–4, DONE 5. No `read_next_value`.
- `start` held high continuously: exactly one pass per IDLE visit; second `read_first_value` at cycle 195 (defaults).
- `reset` asserted at cycle 50 mid-WAIT: cycle 51 all outputs 0, IDLE, `step_cnt`=0. A new `start` gives a normal full pass.
- One-hot checker over all 5 strobes for 3 back-to-back passes: never two strobes high in the same cycle; `step_cnt` is monotonic 0..31 within each pass.
